// File: rtl/rr_mux_pkg.sv
// rr_mux shared constants and helpers.
// Optional burst locking is selected with RR_MUX_LOCK_EN.
package rr_mux_pkg;

    localparam int RR_MUX_N = 4;
    localparam int RR_MUX_W = 8;
    localparam int SEL_W = $clog2(RR_MUX_N);

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Wrap at n itself, so non-power-of-two channel counts work.
    function automatic int next_ptr(input int g, input int n);
        return (g == n - 1) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/rr_mux_if.sv
// Producer/consumer handshake bundle for rr_mux.
// in_last exists only when RR_MUX_LOCK_EN is defined.
interface rr_mux_if
    import rr_mux_pkg::*;
#(
    parameter int N = RR_MUX_N,
    parameter int W = RR_MUX_W
) ();

    localparam int SW = sel_w(N);

    logic [N-1:0]  in_valid;
    logic [W-1:0]  in_data [N];
    logic [N-1:0]  in_ready;
`ifdef RR_MUX_LOCK_EN
    logic [N-1:0]  in_last;
`endif
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [SW-1:0] out_sel;
    logic          out_ready;

`ifdef RR_MUX_LOCK_EN
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
`endif

endinterface

// File: rtl/rr_mux_arbiter.sv
// Combinational rotating-priority arbiter: first request at or after ptr.
// idx/any report the winner regardless of en; only gnt is gated.
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int N = RR_MUX_N,
    parameter int SW = sel_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] idx,
    output logic          any
);

    logic [SW-1:0] pos;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int k = 0; k < N; k++) begin
            pos = SW'((int'(ptr) + k) % N);
            if (!any && req[pos]) begin
                any = 1'b1;
                idx = pos;
            end
        end
        if (any && en) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_mux.sv
// N-channel registered round-robin mux with valid/ready handshakes.
// Define RR_MUX_LOCK_EN to hold a grant until the in_last beat.
module rr_mux
    import rr_mux_pkg::*;
#(
    parameter int N = RR_MUX_N,
    parameter int W = RR_MUX_W
) (
    input logic   clk,
    input logic   rst_n,
    rr_mux_if.slave bus
);

    localparam int SW = sel_w(N);

    logic          out_valid_q;
    logic [W-1:0]  out_data_q;
    logic [SW-1:0] out_sel_q;
    logic [SW-1:0] ptr_q;

    logic          load;
    logic          en;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [SW-1:0] idx;
    logic          any;

    assign load = !out_valid_q || bus.out_ready;
    assign en   = load && rst_n;

`ifdef RR_MUX_LOCK_EN
    logic          lock_q;
    logic [SW-1:0] lch_q;

    // A locked burst masks every channel but its owner.
    always_comb begin
        req = bus.in_valid;
        if (lock_q) begin
            req = '0;
            req[lch_q] = bus.in_valid[lch_q];
        end
    end
`else
    assign req = bus.in_valid;
`endif

    rr_arbiter #(
        .N  (N),
        .SW (SW)
    ) u_arb (
        .req (req),
        .ptr (ptr_q),
        .en  (en),
        .gnt (gnt),
        .idx (idx),
        .any (any)
    );

    assign bus.in_ready  = gnt;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
`ifdef RR_MUX_LOCK_EN
            lock_q      <= 1'b0;
            lch_q       <= '0;
`endif
        end else if (load) begin
            if (any) begin
                out_valid_q <= 1'b1;
                out_data_q  <= bus.in_data[idx];
                out_sel_q   <= idx;
`ifdef RR_MUX_LOCK_EN
                if (bus.in_last[idx]) begin
                    lock_q <= 1'b0;
                    ptr_q  <= SW'(next_ptr(int'(idx), N));
                end else begin
                    lock_q <= 1'b1;
                    lch_q  <= idx;
                end
`else
                ptr_q <= SW'(next_ptr(int'(idx), N));
`endif
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule
